// File: rtl/register_file_if.sv
// register_file_if: register-file read/write bus (two combinational reads, one write)
interface register_file_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] read_reg_1;
  logic [ADDR_WIDTH-1:0] read_reg_2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] data_reg_1;
  logic [DATA_WIDTH-1:0] data_reg_2;
  modport master (output reg_write, read_reg_1, read_reg_2, write_reg, write_data, input data_reg_1, data_reg_2);
  modport slave (input reg_write, read_reg_1, read_reg_2, write_reg, write_data, output data_reg_1, data_reg_2);
endinterface

// File: rtl/register_file.sv
// register_file: 32x24 register file, async reset, sync write, two combinational reads, no bypass
module register_file #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input logic clk,
  input logic rst_n,
  register_file_if.slave bus
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (bus.reg_write) regs[bus.write_reg] <= bus.write_data;
  assign bus.data_reg_1 = regs[bus.read_reg_1];
  assign bus.data_reg_2 = regs[bus.read_reg_2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
  logic clk = 0;
  logic rst_n = 0;
  int errors = 0;
  int checks = 0;
  register_file_if bus ();
  register_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    bus.read_reg_1 = a;
    bus.read_reg_2 = b;
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [23:0] d);
    bus.reg_write = 1;
    bus.write_reg = a;
    bus.write_data = d;
    @(posedge clk);
    #1 bus.reg_write = 0;
  endtask
  initial begin
    bus.reg_write = 1;
    bus.write_reg = 3;
    bus.write_data = 24'h5A5A5A;
    bus.read_reg_1 = 0;
    bus.read_reg_2 = 31;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_r3", dut.regs[3], 24'h0);
    bus.reg_write = 0;
    @(negedge clk) rst_n = 1;
    rd(0, 31);
    chk("rst_p1_r0", bus.data_reg_1, 0);
    chk("rst_p2_r31", bus.data_reg_2, 0);
    rd(31, 0);
    chk("rst_p1_r31", bus.data_reg_1, 0);
    chk("rst_p2_r0", bus.data_reg_2, 0);
    wr(0, 24'd123);
    rd(0, 1);
    chk("r0_write", bus.data_reg_1, 24'd123);
    chk("r1_zero", bus.data_reg_2, 0);
    bus.write_reg = 5;
    bus.write_data = 24'hABCDEF;
    @(posedge clk);
    #1 rd(5, 5);
    chk("wr_disabled", bus.data_reg_1, 0);
    wr(5, 24'hABCDEF);
    rd(5, 5);
    chk("wr_enabled_p1", bus.data_reg_1, 24'hABCDEF);
    chk("wr_enabled_p2", bus.data_reg_2, 24'hABCDEF);
    for (int i = 0; i < 32; i++) wr(i[4:0], 24'(i) * 24'h010101);
    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], 5'(31 - i));
      chk($sformatf("sweep_p1_%0d", i), bus.data_reg_1, 24'(i) * 24'h010101);
      chk($sformatf("sweep_p2_%0d", 31 - i), bus.data_reg_2, 24'(31 - i) * 24'h010101);
    end
    rd(31, 30);
    chk("r31_const", bus.data_reg_1, 24'h1F1F1F);
    chk("r30_const", bus.data_reg_2, 24'h1E1E1E);
    wr(7, 24'h000111);
    rd(7, 7);
    bus.reg_write = 1;
    bus.write_reg = 7;
    bus.write_data = 24'hFFF000;
    #1 chk("rdw_before", bus.data_reg_1, 24'h000111);
    @(posedge clk);
    #1 chk("rdw_after", bus.data_reg_1, 24'hFFF000);
    bus.reg_write = 0;
    rd(7, 9);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async_rst_p1", bus.data_reg_1, 0);
    chk("async_rst_p2", bus.data_reg_2, 0);
    #1 rst_n = 1;
    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], 5'(31 - i));
      chk($sformatf("post_rst_%0d", i), bus.data_reg_1, 0);
    end
    wr(2, 24'h222222);
    @(negedge clk);
    bus.reg_write = 1;
    bus.write_reg = 4;
    bus.write_data = 24'h444444;
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    bus.reg_write = 0;
    rd(4, 2);
    chk("rst_beats_write", bus.data_reg_1, 0);
    chk("rst_clears_r2", bus.data_reg_2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 24-bit general-purpose register file for the multicycle computer datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Read ports feed the ALU operand registers; the write port is driven from the ALU-out/memory-data writeback mux under control-FSM reg_write.
- All 32 entries, including register 0, are ordinary writable storage.

Parameters:
- DATA_WIDTH, 24, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register-select ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- reg_write  input  1  write enable, sampled on rising clk edge.
- read_reg_1  input  5  register select for read port 1.
- read_reg_2  input  5  register select for read port 2.
- write_reg  input  5  register select for the write port.
- write_data  input  24  data written to regs[write_reg].
- data_reg_1  output  24  contents of regs[read_reg_1].
- data_reg_2  output  24  contents of regs[read_reg_2].

Behaviour:
- Storage: array regs[0..31], 24 bits each.
- Reset:
  - rst_n low asynchronously forces every register to 0, independent of clk.
  - Both outputs therefore read 0 during reset.
  - Writes are blocked while rst_n is low.
  - Release is clean; the first write can occur on the first rising edge with rst_n high.
- Write:
  - On rising clk edge with rst_n=1 and reg_write=1: regs[write_reg] <= write_data.
  - With reg_write=0, no register changes.
  - Register 0 is writable; it is not hardwired to zero.
- Read:
  - Purely combinational: data_reg_1 = regs[read_reg_1], data_reg_2 = regs[read_reg_2].
  - Outputs follow address changes within the same cycle; no clock latency.
- Read-during-write to the same address:
  - No bypass. Before the edge, the output shows the old value.
  - Immediately after the edge, the output shows the new value.
- Both read ports may select the same register; both return the identical value.
- Write latency: the value is visible on a read port one clk edge after it is presented with reg_write=1.
- Inputs are not registered. reg_write, write_reg and write_data must be stable around the rising edge.
- No X propagation: all addresses are in range (5 bits, 32 entries), so no out-of-range handling is needed.
- Reset mid-operation:
  - Asserting rst_n at any time, including coincident with a write edge, leaves all registers at 0.
  - Reset wins over write.

Test Plan:
- Reset check: drive rst_n=0 with random stale contents, release, read regs 0 and 31 on both ports -> data_reg_1 = data_reg_2 = 0.
- Write/read reg 0: reg_write=1, write_reg=0, write_data=123, rising edge; then reg_write=0, read_reg_1=0, read_reg_2=1 -> data_reg_1=123, data_reg_2=0.
- Write disable: reg_write=0, write_reg=5, write_data=24'hABCDEF, edge -> read reg 5 = 0; then reg_write=1, edge -> read reg 5 = 24'hABCDEF.
- Full sweep:
  - Write regs[i] = i*24'h010101 for i=0..31.
  - Read pairs (i, 31-i) on both ports -> each port returns the matching value.
  - Reg 31 = 24'h1F1F1F, with no aliasing between entries.
- Read-during-write:
  - read_reg_1=7 holding 24'h000111; write 24'hFFF000 to reg 7.
  - data_reg_1 = 24'h000111 before the edge and 24'hFFF000 after the edge.
- Async reset mid-run:
  - With regs populated, pulse rst_n low between clock edges.
  - data_reg_1 and data_reg_2 drop to 0 immediately, without waiting for clk.
  - All 32 entries read 0 afterwards.
